// File: rtl/sigmoid_share_arbiter.sv
// Round-robin arbiter sharing one combinational Sigmoid LUT among N_REQ accumulators,
// two registered stages, id-tagged results. Optional stall counter: define SIG_ARB_PERF_EN.
module sigmoid_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int N     = 2,
  parameter  int QM    = 6,
  parameter  int QN    = 10,
  localparam int DW    = QM + QN + N,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [DW-1:0]       sig_in,
  input  logic [7:0]          sig_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_data
`ifdef SIG_ARB_PERF_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   sig_in_q, sig_in_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            adv2_s, adv1_s;
  logic            gnt_found_s, grant_s;
  logic [IDW-1:0]  gnt_id_s;

  assign adv2_s = !rsp_valid_q || rsp_ready;
  assign adv1_s = !s1_valid_q || adv2_s;

  // Rotating priority search starting at rr_ptr; the sum cannot overflow IDW+1 bits.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [IDW:0] sum_v;
      sum_v = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum_v >= (IDW+1)'(N_REQ)) begin
        sum_v = sum_v - (IDW+1)'(N_REQ);
      end else begin
        sum_v = sum_v;
      end
      if (!gnt_found_s && req_valid[sum_v[IDW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = sum_v[IDW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Grant is suppressed while reset is asserted so nothing handshakes into a dropped pipe.
  assign grant_s = gnt_found_s && adv1_s && rst_n;

  // One-hot ready toward the requesters.
  always_comb begin
    req_ready = '0;
    if (grant_s) begin
      req_ready[gnt_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for both stages and the round-robin pointer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    sig_in_d    = sig_in_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (adv1_s) begin
      if (grant_s) begin
        sig_in_d   = req_data[gnt_id_s*DW +: DW];
        s1_id_d    = gnt_id_s;
        s1_valid_d = 1'b1;
        rr_ptr_d   = (gnt_id_s == IDW'(N_REQ-1)) ? '0 : gnt_id_s + IDW'(1);
      end else begin
        s1_valid_d = 1'b0;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    // sig_out is only sampled while sig_in is held from the previous grant.
    if (adv2_s) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = sig_out;
        rsp_id_d   = s1_id_q;
      end else begin
        rsp_data_d = rsp_data_q;
      end
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Pipeline and pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      sig_in_q    <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 8'd0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sig_in_q    <= sig_in_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign sig_in    = sig_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef SIG_ARB_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where a result waits on the consumer.
  always_comb begin
    stall_d = stall_q;
    if (rsp_valid_q && !rsp_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
